// File: rtl/zcycle_sync.sv
// zcycle_sync: 4-fclk memory-cycle phase strobes, Z80 half-rate marker, turbo handshake.
// Optional `ZCYCLE_STALL_EN freezes the cycle at phase 3 while stall is high.
module zcycle_sync (
   input  logic       fclk,
   input  logic       rst,
   input  logic [1:0] turbo_req,
   input  logic       turbo_stb,
   input  logic       stall,
   output logic       cbeg,
   output logic       post_cbeg,
   output logic       pre_cend,
   output logic       cend,
   output logic       zpos,
   output logic       zcycle_end,
   output logic [1:0] turbo_out,
   output logic       turbo_ack,
   output logic       turbo_busy
);

   logic [1:0] r_ph;
   logic       r_zpos;
   logic       r_live;
   logic       r_cbeg;
   logic       r_post;
   logic       r_pre;
   logic       r_cend;
   logic       r_zce;
   logic [1:0] r_pend;
   logic [1:0] r_tout;
   logic       r_ack;
   logic       r_busy;
   logic       w_adv;
   logic       w_emit;

`ifdef ZCYCLE_STALL_EN
   assign w_adv = !((r_ph == 2'd3) && stall);
`else
   logic w_unused_stall;
   assign w_unused_stall = stall;
   assign w_adv = 1'b1;
`endif

   // no strobe for the phase held during reset
   assign w_emit = r_live & w_adv;

   always_ff @(posedge fclk) begin
      if (rst) begin
         r_ph   <= 2'd3;
         r_zpos <= 1'b1;
         r_live <= 1'b0;
         r_cbeg <= 1'b0;
         r_post <= 1'b0;
         r_pre  <= 1'b0;
         r_cend <= 1'b0;
         r_zce  <= 1'b0;
      end else begin
         r_live <= 1'b1;
         if (w_adv) begin
            r_ph <= r_ph + 2'd1;
            if (r_ph == 2'd3)
               r_zpos <= ~r_zpos;
         end
         r_cbeg <= w_emit & (r_ph == 2'd0);
         r_post <= w_emit & (r_ph == 2'd1);
         r_pre  <= w_emit & (r_ph == 2'd2);
         r_cend <= w_emit & (r_ph == 2'd3);
         r_zce  <= w_emit & (r_ph == 2'd3) & r_zpos;
      end
   end

   // apply only while zcycle_end is shown; a coincident strobe wins over pend
   always_ff @(posedge fclk) begin
      if (rst) begin
         r_pend <= 2'b00;
         r_tout <= 2'b00;
         r_ack  <= 1'b0;
         r_busy <= 1'b0;
      end else if (r_zce) begin
         if (turbo_stb) begin
            r_tout <= turbo_req;
            r_pend <= turbo_req;
            r_ack  <= 1'b1;
            r_busy <= 1'b0;
         end else if (r_busy) begin
            r_tout <= r_pend;
            r_ack  <= 1'b1;
            r_busy <= 1'b0;
         end else begin
            r_ack  <= 1'b0;
         end
      end else begin
         r_ack <= 1'b0;
         if (turbo_stb) begin
            r_pend <= turbo_req;
            r_busy <= 1'b1;
         end
      end
   end

   assign cbeg       = r_cbeg;
   assign post_cbeg  = r_post;
   assign pre_cend   = r_pre;
   assign cend       = r_cend;
   assign zpos       = r_zpos;
   assign zcycle_end = r_zce;
   assign turbo_out  = r_tout;
   assign turbo_ack  = r_ack;
   assign turbo_busy = r_busy;

endmodule

// File: tb/tb_zcycle_sync.sv
// tb_zcycle_sync: random stimulus against an arithmetic reference model,
// expected outputs queued by the driver and checked by a separate monitor.
module tb_zcycle_sync;

   logic       fclk = 1'b0;
   logic       rst;
   logic [1:0] turbo_req;
   logic       turbo_stb;
   logic       stall;
   logic       cbeg;
   logic       post_cbeg;
   logic       pre_cend;
   logic       cend;
   logic       zpos;
   logic       zcycle_end;
   logic [1:0] turbo_out;
   logic       turbo_ack;
   logic       turbo_busy;

   zcycle_sync dut (
      .fclk       (fclk),
      .rst        (rst),
      .turbo_req  (turbo_req),
      .turbo_stb  (turbo_stb),
      .stall      (stall),
      .cbeg       (cbeg),
      .post_cbeg  (post_cbeg),
      .pre_cend   (pre_cend),
      .cend       (cend),
      .zpos       (zpos),
      .zcycle_end (zcycle_end),
      .turbo_out  (turbo_out),
      .turbo_ack  (turbo_ack),
      .turbo_busy (turbo_busy)
   );

   always #5 fclk = ~fclk;

   logic [9:0] q[$];
   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   bit started = 1'b0;

`ifdef ZCYCLE_STALL_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif

   // order: cbeg post pre cend zpos zce tout[1:0] ack busy
   initial begin
      logic [9:0] exp_v;
      logic [9:0] got_v;
      forever begin
         @(posedge fclk);
         #1;
         cyc++;
         if (started) begin
            got_v = {cbeg, post_cbeg, pre_cend, cend, zpos,
                     zcycle_end, turbo_out, turbo_ack, turbo_busy};
            n_cmp++;
            if (q.size() == 0) begin
               n_bad++;
               $display("FAIL queue_underflow cyc=%0d got=%b", cyc, got_v);
            end else begin
               exp_v = q.pop_front();
               if (got_v !== exp_v) begin
                  n_bad++;
                  $display("FAIL outputs cyc=%0d got=%b exp=%b", cyc, got_v, exp_v);
               end
            end
         end
      end
   end

   // model: n counts phase advances since reset (-1 = reset position)
   int       m_n;
   bit       m_fresh;
   bit       m_zce;
   bit       m_busy;
   bit [1:0] m_pend;
   bit [1:0] m_tout;

   function automatic bit zpos_of(int n);
      return (((n + 4) / 4) % 2) == 0;
   endfunction

   task automatic model_edge();
      bit       adv;
      int       ph;
      bit [3:0] stb;
      bit       zce_n;
      bit       ack;
      if (rst) begin
         m_n = -1;
         m_fresh = 1'b1;
         m_zce = 1'b0;
         m_busy = 1'b0;
         m_pend = 2'b00;
         m_tout = 2'b00;
         q.push_back({4'b0000, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0});
      end else begin
         ph = (m_n + 4) % 4;
         adv = !(STALL_EN && ph == 3 && stall);
         stb = 4'b0000;
         zce_n = 1'b0;
         if (adv && !m_fresh) begin
            stb[3 - ph] = 1'b1;
            zce_n = ((m_n + 8) % 8) == 7;
         end
         ack = 1'b0;
         if (m_zce) begin
            if (turbo_stb) begin
               m_tout = turbo_req;
               ack = 1'b1;
               m_busy = 1'b0;
            end else if (m_busy) begin
               m_tout = m_pend;
               ack = 1'b1;
               m_busy = 1'b0;
            end
         end else if (turbo_stb) begin
            m_pend = turbo_req;
            m_busy = 1'b1;
         end
         if (adv) m_n++;
         m_fresh = 1'b0;
         m_zce = zce_n;
         q.push_back({stb, zpos_of(m_n), zce_n, m_tout, ack, m_busy});
      end
   endtask

   initial begin
      int rst_left;
      int stall_left;
      rst = 1'b1;
      turbo_req = 2'b00;
      turbo_stb = 1'b0;
      stall = 1'b0;
      rst_left = 0;
      stall_left = 0;
      repeat (2) @(negedge fclk);
      for (int c = 0; c < 4000; c++) begin
         @(negedge fclk);
         if (rst_left > 0) rst_left--;
         else if (c >= 80 && $urandom_range(0, 299) == 0)
            rst_left = $urandom_range(1, 3);
         rst = (c < 2) || (rst_left > 0);
         if (stall_left > 0) stall_left--;
         else if (c >= 80 && $urandom_range(0, 15) == 0)
            stall_left = $urandom_range(1, 6);
         stall = (stall_left > 0);
         turbo_stb = (c >= 80) && ($urandom_range(0, 5) == 0);
         turbo_req = 2'($urandom_range(0, 3));
         model_edge();
         started = 1'b1;
      end
      @(negedge fclk);
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL queue_leftover got=%0d exp=0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
